// File: rtl/instruction_fetch_if.sv
// Program memory bus between instruction_fetch (master) and the program ROM (slave).
// The address is combinational from the fetch unit; the ROM returns its word in the same cycle.
interface instruction_fetch_if;
    logic [12:0] pmem_addr;
    logic [13:0] pmem_data;

    modport master (
        output pmem_addr,
        input  pmem_data
    );

    modport slave (
        input  pmem_addr,
        output pmem_data
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: program counter, instruction register, branch flush and circular return stack.
// Define STACK_STATUS_EN to add sticky stack overflow/underflow flags and their clear input.
module instruction_fetch #(
    parameter logic [12:0] RESET_VECTOR = 13'h0000,
    parameter int          STACK_DEPTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    instruction_fetch_if.master  pmem,
    output logic [13:0]          instr_current,
    output logic [12:0]          pc,
    input  logic                 instr_rd_en,
    input  logic                 incr_pc_en,
    input  logic                 pc_load_en,
    input  logic [10:0]          pc_load_target,
    input  logic [4:0]           pclath,
    input  logic                 pcl_wr_en,
    input  logic [7:0]           pcl_wr_data,
    input  logic                 stack_push,
    input  logic                 stack_pop,
    input  logic                 flush
`ifdef STACK_STATUS_EN
    ,
    input  logic                 stack_status_clr,
    output logic                 stack_overflow,
    output logic                 stack_underflow
`endif
);

    localparam int          PTR_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [13:0] NOP   = 14'h0000;

    logic [12:0]      stack_mem [STACK_DEPTH];
    logic [PTR_W-1:0] sp;
    logic [PTR_W-1:0] sp_dec;
    logic             flush_pending;
    logic             do_push;
    logic             incr_ok;
    logic [12:0]      pc_next;

    assign pmem.pmem_addr = pc;
    assign sp_dec         = sp - PTR_W'(1);

    // A pop in the same cycle as a push wins; the push is dropped entirely.
    assign do_push = stack_push & ~stack_pop;

    // The forced-NOP latch must not advance pc, or the branch target word would be skipped.
    assign incr_ok = incr_pc_en & ~(flush_pending & instr_rd_en);

    always_comb begin
        // NOTE: assigning a default first keeps this block free of inferred latches.
        pc_next = pc;
        if (stack_pop)
            pc_next = stack_mem[sp_dec];
        else if (pc_load_en)
            pc_next = {pclath[4:3], pc_load_target};
        else if (pcl_wr_en)
            pc_next = {pclath, pcl_wr_data};
        else if (incr_ok)
            pc_next = pc + 13'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_VECTOR;
            instr_current <= NOP;
            sp            <= '0;
            flush_pending <= 1'b0;
        end else begin
            pc <= pc_next;

            if (instr_rd_en)
                instr_current <= flush_pending ? NOP : pmem.pmem_data;

            if (flush)
                flush_pending <= 1'b1;
            else if (instr_rd_en)
                flush_pending <= 1'b0;

            if (stack_pop)
                sp <= sp_dec;
            else if (do_push)
                sp <= sp + PTR_W'(1);
        end
    end

    // NOTE: the stack array is deliberately not reset; an entry is meaningful only once pushed.
    always_ff @(posedge clk) begin
        if (!rst && do_push)
            stack_mem[sp] <= pc;
    end

`ifdef STACK_STATUS_EN
    localparam int               CNT_W = $clog2(STACK_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(STACK_DEPTH);

    logic [CNT_W-1:0] occupancy;
    logic             overflow_set;
    logic             underflow_set;

    assign overflow_set  = do_push & (occupancy == FULL);
    assign underflow_set = stack_pop & (occupancy == '0);

    // Occupancy saturates at both ends so the flags keep meaning after a wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            occupancy       <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            if (stack_pop && !underflow_set)
                occupancy <= occupancy - CNT_W'(1);
            else if (do_push && !overflow_set)
                occupancy <= occupancy + CNT_W'(1);

            if (stack_status_clr) begin
                stack_overflow  <= 1'b0;
                stack_underflow <= 1'b0;
            end else begin
                if (overflow_set)
                    stack_overflow <= 1'b1;
                if (underflow_set)
                    stack_underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Supplies instructions to instruction_decoder and acts on its fetch/PC requests. Holds the program counter, the instruction register (instr_current), and the 8-level hardware return stack. It also handles the branch flush that turns the prefetched word into a forced NOP. Sits between the program ROM and instruction_decoder, and takes PCLATH from the register file.

Parameters:
RESET_VECTOR, 13'h0000, PC value loaded on reset
STACK_DEPTH, 8, return stack entries; must be a power of two; pointer width is log2(STACK_DEPTH)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
pmem_addr  out  13  program memory address; combinational, equals pc
pmem_data  in  14  program memory word; combinational read of pmem_addr, valid in the same cycle
instr_current  out  14  instruction register, to decoder
pc  out  13  current program counter
instr_rd_en  in  1  latch instruction register this edge
incr_pc_en  in  1  pc <= pc+1 this edge
pc_load_en  in  1  GOTO/CALL: pc <= {pclath[4:3], pc_load_target}
pc_load_target  in  11  branch target from instruction k field
pclath  in  5  PCLATH register value
pcl_wr_en  in  1  computed jump: pc <= {pclath, pcl_wr_data}
pcl_wr_data  in  8  new PCL value
stack_push  in  1  push pc (value before this edge) onto return stack
stack_pop  in  1  RETURN/RETLW: pc <= top of stack
flush  in  1  next instruction latch loads NOP instead of pmem_data

Behaviour:
- Reset, all synchronous:
  - pc = RESET_VECTOR; instr_current = 14'h0000 (NOP); stack pointer sp = 0; flush_pending = 0.
  - Stack contents are not reset.
  - Reset overrides every other input in the same cycle.
- Instruction register update on an edge with instr_rd_en=1:
  - If flush_pending=0: instr_current <= pmem_data (the word at the pre-edge pc).
  - If flush_pending=1: instr_current <= 14'h0000 and flush_pending <= 0.
  - When instr_rd_en=0, instr_current holds.
- Flush:
  - flush=1 sets flush_pending on that edge.
  - If flush and instr_rd_en are both 1 in the same cycle, the current latch is normal and the following latch is the forced NOP.
- PC update priority, exactly one applies per edge: stack_pop > pc_load_en > pcl_wr_en > incr_pc_en > hold.
  - incr_pc_en is ignored on an edge where flush_pending=1 and instr_rd_en=1. This keeps the forced-NOP cycle from skipping the branch target.
  - Increment wraps 13'h1FFF -> 13'h0000.
- Return stack: circular, PIC-style, with no stall or trap.
  - Push: stack[sp] <= pc (pre-edge); sp <= sp+1 mod STACK_DEPTH. Overflow silently overwrites the oldest entry.
  - Pop: sp <= sp-1 mod STACK_DEPTH; pc <= stack[sp-1]. Underflow wraps and returns a stale entry.
  - CALL uses stack_push and pc_load_en in the same cycle. The pushed value is the pre-load pc, which the decoder has already incremented in Q1.
  - stack_push and stack_pop in the same cycle: the pop executes and the push is ignored.
- Latency: pmem_addr follows pc combinationally. instr_current reflects the new word one edge after instr_rd_en.
- No internal timing. The Q-cycle sequencing is owned by instruction_decoder.

Optional Feature:
STACK_STATUS_EN
- Defined: adds outputs stack_overflow (1) and stack_underflow (1), plus input stack_status_clr (1).
  - stack_overflow sets when a push occurs with the stack already holding STACK_DEPTH entries.
  - stack_underflow sets when a pop occurs with zero entries.
  - An occupancy counter tracks entries from 0 to STACK_DEPTH.
  - Both flags are sticky. They clear on rst or stack_status_clr; clr wins over a same-cycle set.
- Undefined: ports and counter are absent; stack behaviour is otherwise identical.

Test Plan:
- Reset with pmem[0]=14'h3005, pmem[1]=14'h0000 -> pc=0, instr_current=0. After one edge with instr_rd_en=1 and incr_pc_en=1: instr_current=14'h3005, pc=1.
- Sequential fetch of 4 words, each with rd+incr -> instr_current=pmem[0..3] in order, pc=4.
- GOTO at pc=5: pclath=5'b11000, target=11'h123, pc_load_en=1, flush=1 -> pc=13'h1923. Next rd+incr latches NOP with pc still 13'h1923. The following rd+incr latches pmem[13'h1923] and pc=13'h1924.
- CALL at pc=13'h0010 to target 11'h200 (push+load), then RETURN (pop) -> pc=13'h0200, then pc=13'h0010.
- 9 consecutive pushes of pc values 1..9, then 1 pop -> pc=9. The 8th further pop returns 9 (1 was overwritten). With STACK_STATUS_EN, stack_overflow=1 after the 9th push; stack_status_clr clears it.
- Same-cycle stack_pop, pc_load_en and incr_pc_en with top of stack 13'h0042 -> pc=13'h0042, sp decremented. pc=13'h1FFF with incr -> 13'h0000.
